// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// FIFO_ARB_PKT_LOCK_EN selects packet-lock release in the top module.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams, FIFO write port and arbiter status bundled as one interface.
// master = arbiter side, slave = requesters/FIFO side.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32
) ();
   localparam int ID_W = fifo_arb_pkg::id_width(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_din;
   logic                          fifo_full;
   logic [ID_W-1:0]               grant_id;
   logic                          busy;

   modport master (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_wr_en, fifo_din, grant_id, busy
   );

   modport slave (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of i_req searching upward from i_start.
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   i_req,
   input  logic [IDW-1:0] i_start,
   output logic           o_found,
   output logic [IDW-1:0] o_idx
);
   logic [IDW-1:0] w_cand;

   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_cand  = '0;
      for (int k = 0; k < N; k++) begin
         w_cand = IDW'((int'(i_start) + k) % N);
         if (!o_found && i_req[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-based round-robin arbiter owning one FIFO write port.
// FIFO_ARB_PKT_LOCK_EN: hold each grant until the req_last beat is written.
//
// state     | meaning
// ARB_IDLE  | no owner; pick next valid requester from rr_ptr
// ARB_GRANT | grant_id owns the FIFO port until release
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input  logic           clk,
   input  logic           rst,
   fifo_wr_arbiter_if.master bus
);
   localparam int ID_W  = id_width(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;
   localparam logic [ID_W-1:0]  ID_TOP  = ID_W'(NUM_REQ - 1);

   arb_state_e         r_state, w_next_state;
   logic [ID_W-1:0]    r_rr_ptr, r_grant_id, w_pick_idx, w_grant_inc;
   logic [CNT_W-1:0]   r_beat_cnt;
   logic               w_pick_found, w_g_valid, w_g_last, w_transfer, w_release;
   logic [NUM_REQ-1:0] w_ready;
   logic               w_wr_en;

   rr_pick #(.N(NUM_REQ), .IDW(ID_W)) u_pick (
      .i_req   (bus.req_valid),
      .i_start (r_rr_ptr),
      .o_found (w_pick_found),
      .o_idx   (w_pick_idx)
   );

   assign w_g_valid   = bus.req_valid[r_grant_id];
   assign w_grant_inc = (r_grant_id == ID_TOP) ? '0 : r_grant_id + 1'b1;

`ifdef FIFO_ARB_PKT_LOCK_EN
   assign w_g_last = bus.req_last[r_grant_id];
`else
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
   logic w_unused_last;
   assign w_unused_last = ^bus.req_last;
   assign w_g_last      = (r_beat_cnt == CNT_LAST);
`endif

   always_comb begin
      w_next_state = r_state;
      w_ready      = '0;
      w_wr_en      = 1'b0;
      w_transfer   = 1'b0;
      w_release    = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_found) w_next_state = ARB_GRANT;
         end
         ARB_GRANT: begin
            // a full FIFO freezes the grant completely, gap or not
            if (!bus.fifo_full) begin
               w_ready[r_grant_id] = 1'b1;
               w_wr_en             = w_g_valid;
               w_transfer          = w_g_valid;
`ifdef FIFO_ARB_PKT_LOCK_EN
               w_release = w_g_valid & w_g_last;
`else
               w_release = ~w_g_valid | w_g_last;
`endif
               if (w_release) w_next_state = ARB_IDLE;
            end
         end
         default: w_next_state = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ARB_IDLE;
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == ARB_IDLE && w_pick_found) begin
            r_grant_id <= w_pick_idx;
            r_beat_cnt <= '0;
         end
         if (w_transfer && r_beat_cnt != CNT_SAT) r_beat_cnt <= r_beat_cnt + 1'b1;
         if (w_release) r_rr_ptr <= w_grant_inc;
      end
   end

   assign bus.req_ready  = rst ? '0 : w_ready;
   assign bus.fifo_wr_en = w_wr_en & ~rst;
   assign bus.fifo_din   = bus.req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
   assign bus.grant_id   = r_grant_id;
   assign bus.busy       = (r_state == ARB_GRANT) & ~rst;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4).
module tb_fifo_wr_arbiter;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   r_cnt [4];

   fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] data_of(input int i, input int n);
      return 32'hD000_0000 | (32'(i) << 16) | 32'(n);
   endfunction

   // requester sources: beat counter advances on each accepted beat
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rst) r_cnt[i] <= 0;
         else if (bus.req_valid[i] && bus.req_ready[i]) r_cnt[i] <= r_cnt[i] + 1;
      end
   end

   always_comb begin
      bus.req_data = '0;
      bus.req_last = '0;
      for (int i = 0; i < 4; i++) begin
         bus.req_data[i*32 +: 32] = data_of(i, r_cnt[i]);
         bus.req_last[i]          = (r_cnt[i] == 6);
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      bus.fifo_full = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid = 4'hF;
      bus.fifo_full = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready c=%0d got %b want 0000", c, bus.req_ready); end
         checks++;
         if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en c=%0d got %b want 0", c, bus.fifo_wr_en); end
         checks++;
         if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant c=%0d got %0d want 0", c, bus.grant_id); end
         checks++;
         if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy c=%0d got %b want 0", c, bus.busy); end
      end
   endtask

   task automatic test_round_robin();
      int pos, gnum, gid, beat;
      do_reset();
      for (int k = 0; k < 25; k++) begin
         bus.req_valid = 4'hF;
         #1;
         pos  = k % 5;
         gnum = k / 5;
         gid  = gnum % 4;
         beat = (gnum / 4) * 4 + pos - 1;
         checks++;
         if (bus.fifo_wr_en !== (pos != 0)) begin errors++; $display("FAIL rr_wr_en k=%0d got %b want %b", k, bus.fifo_wr_en, pos != 0); end
         if (pos == 0) begin
            checks++;
            if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL rr_idle_ready k=%0d got %b want 0000", k, bus.req_ready); end
         end else begin
            checks++;
            if (bus.grant_id !== 2'(gid)) begin errors++; $display("FAIL rr_grant k=%0d got %0d want %0d", k, bus.grant_id, gid); end
            checks++;
            if (bus.fifo_din !== data_of(gid, beat)) begin errors++; $display("FAIL rr_din k=%0d got %h want %h", k, bus.fifo_din, data_of(gid, beat)); end
            checks++;
            if (bus.req_ready !== 4'(1 << gid)) begin errors++; $display("FAIL rr_ready k=%0d got %b want %b", k, bus.req_ready, 4'(1 << gid)); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      logic exp_wr;
      int   beat;
      do_reset();
      for (int k = 0; k < 11; k++) begin
         bus.req_valid = 4'b0100;
         bus.fifo_full = (k >= 3 && k <= 7);
         #1;
         exp_wr = (k == 1 || k == 2 || k == 8 || k == 9);
         beat   = (k <= 2) ? k - 1 : k - 6;
         checks++;
         if (bus.fifo_wr_en !== exp_wr) begin errors++; $display("FAIL bp_wr_en k=%0d got %b want %b", k, bus.fifo_wr_en, exp_wr); end
         if (exp_wr) begin
            checks++;
            if (bus.fifo_din !== data_of(2, beat)) begin errors++; $display("FAIL bp_din k=%0d got %h want %h", k, bus.fifo_din, data_of(2, beat)); end
         end
         if (k >= 3 && k <= 7) begin
            checks++;
            if (bus.grant_id !== 2'd2 || bus.busy !== 1'b1 || bus.req_ready !== 4'h0) begin
               errors++; $display("FAIL bp_hold k=%0d got gid=%0d busy=%b ready=%b want gid=2 busy=1 ready=0000", k, bus.grant_id, bus.busy, bus.req_ready);
            end
            checks++;
            if (dut.r_beat_cnt !== 3'd2) begin errors++; $display("FAIL bp_beat_cnt k=%0d got %0d want 2", k, dut.r_beat_cnt); end
         end
`ifndef FIFO_ARB_PKT_LOCK_EN
         if (k == 10) begin
            checks++;
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_release k=%0d got busy=%b want 0", k, bus.busy); end
         end
`endif
         @(negedge clk);
      end
      bus.fifo_full = 1'b0;
   endtask

`ifndef FIFO_ARB_PKT_LOCK_EN
   task automatic test_gap_release();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         bus.req_valid = 4'b1000 | ((k < 3) ? 4'b0010 : 4'b0000);
         #1;
         checks++;
         if (bus.fifo_wr_en !== (k == 1 || k == 2 || k == 5)) begin errors++; $display("FAIL gap_wr_en k=%0d got %b want %b", k, bus.fifo_wr_en, (k == 1 || k == 2 || k == 5)); end
         if (k == 1 || k == 2) begin
            checks++;
            if (bus.fifo_din !== data_of(1, k - 1) || bus.req_ready !== 4'b0010) begin
               errors++; $display("FAIL gap_r1 k=%0d got din=%h ready=%b want din=%h ready=0010", k, bus.fifo_din, bus.req_ready, data_of(1, k - 1));
            end
         end
         if (k == 3) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL gap_hold k=%0d got busy=%b gid=%0d want busy=1 gid=1", k, bus.busy, bus.grant_id); end
         end
         if (k == 4) begin
            checks++;
            if (bus.busy !== 1'b0 || dut.r_rr_ptr !== 2'd2) begin errors++; $display("FAIL gap_idle k=%0d got busy=%b rr_ptr=%0d want busy=0 rr_ptr=2", k, bus.busy, dut.r_rr_ptr); end
         end
         if (k == 5) begin
            checks++;
            if (bus.grant_id !== 2'd3 || bus.fifo_din !== data_of(3, 0)) begin
               errors++; $display("FAIL gap_next k=%0d got gid=%0d din=%h want gid=3 din=%h", k, bus.grant_id, bus.fifo_din, data_of(3, 0));
            end
         end
         @(negedge clk);
      end
   endtask
`else
   task automatic test_pkt_lock();
      logic exp_wr;
      int   beat;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         bus.req_valid = 4'b0010 | ((k != 4 && k != 5 && r_cnt[0] < 7) ? 4'b0001 : 4'b0000);
         #1;
         exp_wr = (k >= 1 && k <= 3) || (k >= 6 && k <= 9) || k == 11;
         beat   = (k <= 3) ? k - 1 : k - 3;
         checks++;
         if (bus.fifo_wr_en !== exp_wr) begin errors++; $display("FAIL pkt_wr_en k=%0d got %b want %b", k, bus.fifo_wr_en, exp_wr); end
         if (k >= 1 && k <= 9) begin
            checks++;
            if (bus.grant_id !== 2'd0 || bus.busy !== 1'b1) begin errors++; $display("FAIL pkt_lock k=%0d got gid=%0d busy=%b want gid=0 busy=1", k, bus.grant_id, bus.busy); end
            if (exp_wr) begin
               checks++;
               if (bus.fifo_din !== data_of(0, beat)) begin errors++; $display("FAIL pkt_din k=%0d got %h want %h", k, bus.fifo_din, data_of(0, beat)); end
            end
         end
         if (k == 10) begin
            checks++;
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL pkt_release k=%0d got busy=%b want 0", k, bus.busy); end
         end
         if (k == 11) begin
            checks++;
            if (bus.grant_id !== 2'd1 || bus.fifo_din !== data_of(1, 0)) begin
               errors++; $display("FAIL pkt_next k=%0d got gid=%0d din=%h want gid=1 din=%h", k, bus.grant_id, bus.fifo_din, data_of(1, 0));
            end
         end
         @(negedge clk);
      end
   endtask
`endif

   task automatic test_mid_reset();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         rst           = (k == 3);
         bus.req_valid = (k < 3) ? 4'b0110 : 4'b1111;
         #1;
         checks++;
         if (bus.fifo_wr_en !== (k == 1 || k == 2 || k == 5)) begin errors++; $display("FAIL mr_wr_en k=%0d got %b want %b", k, bus.fifo_wr_en, (k == 1 || k == 2 || k == 5)); end
         if (k == 3) begin
            checks++;
            if (bus.req_ready !== 4'h0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mr_in_reset k=%0d got ready=%b busy=%b want 0000/0", k, bus.req_ready, bus.busy); end
         end
         if (k == 4) begin
            checks++;
            if (bus.grant_id !== 2'd0 || dut.r_rr_ptr !== 2'd0 || bus.busy !== 1'b0) begin
               errors++; $display("FAIL mr_after k=%0d got gid=%0d rr_ptr=%0d busy=%b want 0/0/0", k, bus.grant_id, dut.r_rr_ptr, bus.busy);
            end
         end
         if (k == 5) begin
            checks++;
            if (bus.grant_id !== 2'd0 || bus.fifo_din !== data_of(0, 0)) begin
               errors++; $display("FAIL mr_next k=%0d got gid=%0d din=%h want gid=0 din=%h", k, bus.grant_id, bus.fifo_din, data_of(0, 0));
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.fifo_full = 1'b0;
      @(negedge clk);
      test_reset();
`ifndef FIFO_ARB_PKT_LOCK_EN
      test_round_robin();
`endif
      test_backpressure();
`ifndef FIFO_ARB_PKT_LOCK_EN
      test_gap_release();
`else
      test_pkt_lock();
`endif
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
